// File: rtl/data_sync_tx.sv
// Source-domain launcher for a multi-bit DATA_SYNC crossing: holds a word on unsync_bus and
// runs a 4-phase req/ack handshake (bus_enable = req, bus_ack = returned ack).
`timescale 1ns/1ps

module data_sync_tx #(
    parameter int unsigned NUM_STAGES = 2,
    parameter int unsigned BUS_WIDTH  = 8,
    parameter int unsigned TIMEOUT    = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [BUS_WIDTH-1:0] unsync_bus,
    output logic                 bus_enable,
    input  logic                 bus_ack,
    output logic                 tx_done,
    output logic                 tx_err,
    output logic                 busy
);

    localparam int unsigned CntW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StReq, StRel} state_e;

    state_e                 state_q, state_d;
    logic [NUM_STAGES-1:0]  ack_sync_q;
    logic                   ack_s;
    logic [CntW-1:0]        cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0]   bus_q, bus_d;
    logic                   req_q, req_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic                   to_q, to_d;
    logic                   timeout_hit;

    // bus_ack is asynchronous to CLK; only the last stage is used by the FSM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ack_sync_q <= '0;
        end else begin
            ack_sync_q <= {ack_sync_q[NUM_STAGES-2:0], bus_ack};
        end
    end

    assign ack_s = ack_sync_q[NUM_STAGES-1];

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CntW'(TIMEOUT - 1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bus_q   <= '0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bus_q   <= bus_d;
            req_q   <= req_d;
            done_q  <= done_d;
            err_q   <= err_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bus_d   = bus_q;
        req_d   = req_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        to_d    = to_q;
        unique case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    bus_d   = tx_data;
                    req_d   = 1'b1;
                    cnt_d   = '0;
                    to_d    = 1'b0;
                    state_d = StReq;
                end
            end
            StReq: begin
                // A late ack coinciding with the timeout still counts as success.
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = StRel;
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    to_d    = 1'b1;
                    state_d = StRel;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRel: begin
                if (!ack_s) begin
                    done_d  = !to_q;
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign tx_ready   = (state_q == StIdle);
    assign busy       = (state_q != StIdle);
    assign unsync_bus = bus_q;
    assign bus_enable = req_q;
    assign tx_done    = done_q;
    assign tx_err     = err_q;

endmodule

// File: tb/tb_data_sync_tx.sv
// Directed bench for data_sync_tx with a 3-flop far-clock loopback from bus_enable to bus_ack.
`timescale 1ns/1ps

module tb_data_sync_tx;

    logic       CLK_tb = 1'b0;
    logic       far_clk = 1'b0;
    logic       RST;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] unsync_bus;
    logic       bus_enable;
    logic       bus_ack;
    logic       tx_done;
    logic       tx_err;
    logic       busy;

    logic [2:0] far_q = 3'b000;
    logic       loop_en;
    logic       ack_force;

    int n_vec  = 0;
    int n_miss = 0;

    always #5   CLK_tb  = ~CLK_tb;
    always #3.5 far_clk = ~far_clk;

    always @(posedge far_clk) far_q <= {far_q[1:0], bus_enable};

    assign bus_ack = loop_en ? far_q[2] : ack_force;

    data_sync_tx #(
        .NUM_STAGES (2),
        .BUS_WIDTH  (8),
        .TIMEOUT    (64)
    ) dut (
        .CLK        (CLK_tb),
        .RST        (RST),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .unsync_bus (unsync_bus),
        .bus_enable (bus_enable),
        .bus_ack    (bus_ack),
        .tx_done    (tx_done),
        .tx_err     (tx_err),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK_tb);
        #1;
    endtask

    // Tick until busy drops, tallying pulses and any bus change while busy.
    task automatic run_until_idle(input int max_cyc, input logic [7:0] held,
                                  output int nd, output int ne, output bit moved,
                                  output bit hung);
        nd = 0; ne = 0; moved = 1'b0; hung = 1'b1;
        for (int i = 0; i < max_cyc; i++) begin
            tick();
            nd += int'(tx_done);
            ne += int'(tx_err);
            if (busy && unsync_bus !== held) moved = 1'b1;
            if (!busy) begin
                hung = 1'b0;
                break;
            end
        end
    endtask

    int  nd, ne, nd_tot;
    bit  moved, hung, flag;

    initial begin
        RST = 1'b1; tx_data = 8'h00; tx_valid = 1'b0; loop_en = 1'b1; ack_force = 1'b0;

        // Reset state
        tick(); tick();
        check("rst_bus",   {24'd0, unsync_bus}, 32'h00);
        check("rst_en",    {31'd0, bus_enable}, 32'd0);
        check("rst_ready", {31'd0, tx_ready},   32'd1);
        check("rst_busy",  {31'd0, busy},       32'd0);
        check("rst_pulse", {30'd0, tx_done, tx_err}, 32'd0);
        RST = 1'b0;
        tick(); tick();

        // 1: single transfer of AB
        tx_data = 8'hAB; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("t1_bus",   {24'd0, unsync_bus}, 32'hAB);
        check("t1_en",    {31'd0, bus_enable}, 32'd1);
        check("t1_ready", {31'd0, tx_ready},   32'd0);
        run_until_idle(100, 8'hAB, nd, ne, moved, hung);
        check("t1_hung",  {31'd0, hung},  32'd0);
        check("t1_done",  nd,             32'd1);
        check("t1_err",   ne,             32'd0);
        check("t1_moved", {31'd0, moved}, 32'd0);
        tick();
        check("t1_hold",  {24'd0, unsync_bus}, 32'hAB);
        check("t1_idle",  {31'd0, busy},       32'd0);
        tick(); tick(); tick(); tick();

        // 2: back-to-back AB then CD with tx_valid held high
        tx_data = 8'hAB; tx_valid = 1'b1;
        tick();
        tx_data = 8'hCD;
        check("t2_bus_ab", {24'd0, unsync_bus}, 32'hAB);
        nd_tot = 0; moved = 1'b0; flag = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            if ((busy || bus_enable) && unsync_bus !== 8'hAB) moved = 1'b1;
            if (tx_done) begin
                flag = 1'b0;
                break;
            end
        end
        nd_tot += int'(!flag);
        check("t2_first_hung", {31'd0, flag},     32'd0);
        check("t2_moved_ab",   {31'd0, moved},    32'd0);
        check("t2_ready_done", {31'd0, tx_ready}, 32'd1);
        tick();
        tx_valid = 1'b0;
        check("t2_bus_cd", {24'd0, unsync_bus}, 32'hCD);
        check("t2_en_cd",  {31'd0, bus_enable}, 32'd1);
        run_until_idle(100, 8'hCD, nd, ne, moved, hung);
        nd_tot += nd;
        check("t2_hung",     {31'd0, hung},  32'd0);
        check("t2_moved_cd", {31'd0, moved}, 32'd0);
        tick(); tick();
        nd_tot += int'(tx_done);
        check("t2_done_cnt", nd_tot, 32'd2);
        tick(); tick(); tick(); tick();

        // 3: no ack -> timeout after exactly 64 cycles of bus_enable
        loop_en = 1'b0; ack_force = 1'b0;
        tx_data = 8'h5A; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        flag = 1'b1;
        for (int i = 0; i < 63; i++) begin
            if (bus_enable !== 1'b1 || tx_err !== 1'b0) flag = 1'b0;
            tick();
        end
        if (bus_enable !== 1'b1 || tx_err !== 1'b0) flag = 1'b0;
        check("t3_en_64", {31'd0, flag}, 32'd1);
        tick();
        check("t3_en_off", {31'd0, bus_enable}, 32'd0);
        check("t3_err",    {31'd0, tx_err},     32'd1);
        check("t3_busy",   {31'd0, busy},       32'd1);
        tick();
        check("t3_err_1cy", {31'd0, tx_err},   32'd0);
        check("t3_ready",   {31'd0, tx_ready}, 32'd1);
        check("t3_no_done", {31'd0, tx_done},  32'd0);
        check("t3_bus",     {24'd0, unsync_bus}, 32'h5A);
        tick();
        check("t3_no_done2", {31'd0, tx_done}, 32'd0);
        loop_en = 1'b1;
        tick(); tick(); tick(); tick();

        // 4: tx_valid pulsed with FF while busy is ignored
        tx_data = 8'h12; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check("t4_ready_busy", {31'd0, tx_ready}, 32'd0);
        tx_data = 8'hFF; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("t4_bus_kept", {24'd0, unsync_bus}, 32'h12);
        run_until_idle(100, 8'h12, nd, ne, moved, hung);
        check("t4_hung",  {31'd0, hung},  32'd0);
        check("t4_done",  nd,             32'd1);
        check("t4_moved", {31'd0, moved}, 32'd0);
        tick(); tick();
        check("t4_no_reissue", {31'd0, busy},       32'd0);
        check("t4_bus_final",  {24'd0, unsync_bus}, 32'h12);
        tick(); tick(); tick();

        // 5: reset mid-REQ, then a clean transfer of 3C
        tx_data = 8'h99; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick();
        check("t5_in_req", {31'd0, bus_enable}, 32'd1);
        #2 RST = 1'b1;
        #1;
        check("t5_en_async",  {31'd0, bus_enable}, 32'd0);
        check("t5_bus_async", {24'd0, unsync_bus}, 32'h00);
        check("t5_busy",      {31'd0, busy},       32'd0);
        tick();
        RST = 1'b0;
        flag = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (tx_done || tx_err || busy) flag = 1'b1;
        end
        check("t5_no_pulse", {31'd0, flag}, 32'd0);
        tx_data = 8'h3C; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("t5_bus_3c", {24'd0, unsync_bus}, 32'h3C);
        run_until_idle(100, 8'h3C, nd, ne, moved, hung);
        check("t5_hung", {31'd0, hung}, 32'd0);
        check("t5_done", nd,            32'd1);
        check("t5_err",  ne,            32'd0);
        tick(); tick(); tick(); tick();

        // 6: ack held high 20 cycles in REL
        loop_en = 1'b0; ack_force = 1'b0;
        tx_data = 8'h66; tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        tick(); tick(); tick();
        ack_force = 1'b1;
        flag = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!bus_enable) begin
                flag = 1'b0;
                break;
            end
        end
        check("t6_en_drop", {31'd0, flag}, 32'd0);
        flag = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (!busy || tx_done || bus_enable) flag = 1'b1;
        end
        check("t6_held_rel", {31'd0, flag}, 32'd0);
        ack_force = 1'b0;
        tick(); tick();
        check("t6_still_rel", {30'd0, busy, tx_done}, 32'd2);
        tick();
        check("t6_done",      {31'd0, tx_done}, 32'd1);
        check("t6_idle",      {31'd0, busy},    32'd0);
        tick();
        check("t6_done_1cy",  {31'd0, tx_done}, 32'd0);
        check("t6_bus",       {24'd0, unsync_bus}, 32'h66);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
